// File: rtl/if_fetch_stage_pkg.sv
// Shared constants, FSM encodings and the fetch-buffer entry type for the IF stage.
package if_fetch_stage_pkg;

  localparam logic [31:0] NOP              = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam logic [0:0] IF_FETCH = 1'b0;
  localparam logic [0:0] IF_DROP  = 1'b1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_fetch_stage_fetch_fifo.sv
// Fetch buffer of {pc,inst} entries with flush and "retain head+1 only" for redirects.
module if_fetch_stage_fetch_fifo
  import if_fetch_stage_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  input  logic          flush,
  input  logic          keep_second,
  output fetch_entry_t  head_data,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd_p0, wr_p0;
  logic [PW-1:0] rd_nxt, wr_base;
  logic [CW-1:0] cnt_p0, cnt_base;

  assign head_data = mem[rd_p0];
  assign count     = cnt_p0;
  assign empty     = (cnt_p0 == '0);
  assign full      = (cnt_p0 == CW'(DEPTH));

  // Occupancy after flush/keep/pop; a push in the same cycle lands on top of this.
  always_comb begin
    rd_nxt   = rd_p0;
    wr_base  = wr_p0;
    cnt_base = cnt_p0;
    if (flush) begin
      rd_nxt   = wr_p0;
      cnt_base = '0;
    end else if (keep_second) begin
      rd_nxt   = rd_p0 + PW'(1);
      cnt_base = (cnt_p0 >= CW'(2)) ? CW'(1) : '0;
      wr_base  = rd_nxt + cnt_base[PW-1:0];
    end else if (pop && !empty) begin
      rd_nxt   = rd_p0 + PW'(1);
      cnt_base = cnt_p0 - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_p0  <= '0;
      wr_p0  <= '0;
      cnt_p0 <= '0;
    end else begin
      rd_p0  <= rd_nxt;
      wr_p0  <= wr_base + PW'(push);
      cnt_p0 <= cnt_base + CW'(push);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_base] <= push_data;
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives IMEM requests, buffers words for decode.
// Define IF_DELAY_SLOT_EN to keep the MIPS branch delay slot across a redirect.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imemReq_o,
  output logic [31:0] imemAddr_o,
  input  logic        imemAck_i,
  input  logic [31:0] imemData_i,
  input  logic        stall_i,
  input  logic        branchEnable_i,
  input  logic [31:0] branchAddr_i,
  output logic        instValid_o,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [0:0]    state_p0, state_nxt;
  logic [31:0]   fetch_pc_p0, fetch_pc_nxt;
  logic          vld_p0, vld_nxt;
  logic [31:0]   req_addr_p0, req_addr_nxt;
`ifdef IF_DELAY_SLOT_EN
  logic          ds_pending_p0, ds_pending_nxt;
  logic [31:0]   ds_target_p0, ds_target_nxt;
`endif

  logic          fifo_push, fifo_pop, fifo_flush, fifo_keep;
  logic          fifo_empty, fifo_full;
  logic [CW-1:0] fifo_count, cnt_base, cnt_next;
  fetch_entry_t  push_entry, head_entry;

  logic          consume, redirect, ack, req_busy, issue;
  logic [31:0]   target;

  assign consume    = instValid_o && !stall_i;
  assign redirect   = branchEnable_i && consume;
  assign ack        = vld_p0 && imemAck_i;
  assign target     = word_align(branchAddr_i);
  assign push_entry = '{pc: req_addr_p0, inst: imemData_i};

  always_comb begin
    state_nxt    = state_p0;
    fetch_pc_nxt = fetch_pc_p0;
    fifo_push    = 1'b0;
    fifo_pop     = 1'b0;
    fifo_flush   = 1'b0;
    fifo_keep    = 1'b0;
`ifdef IF_DELAY_SLOT_EN
    ds_pending_nxt = ds_pending_p0;
    ds_target_nxt  = ds_target_p0;
`endif
    if (redirect) begin
      fetch_pc_nxt = target;
`ifdef IF_DELAY_SLOT_EN
      fifo_keep = 1'b1;
      if (state_p0 == IF_DROP) begin
        if (ack) state_nxt = IF_FETCH;
      end else if (fifo_count >= CW'(2)) begin
        if (vld_p0 && !ack) state_nxt = IF_DROP;
      end else if (ack) begin
        fifo_push = 1'b1;
      end else begin
        // Delay slot still to come: keep fetching sequentially for one more word.
        fetch_pc_nxt   = fetch_pc_p0;
        ds_pending_nxt = 1'b1;
        ds_target_nxt  = target;
      end
`else
      fifo_flush = 1'b1;
      if (vld_p0 && !ack) state_nxt = IF_DROP;
`endif
    end else begin
      fifo_pop = consume;
      if (ack) begin
        if (state_p0 == IF_DROP) begin
          state_nxt = IF_FETCH;
        end else begin
          fifo_push = 1'b1;
`ifdef IF_DELAY_SLOT_EN
          if (ds_pending_p0) begin
            fetch_pc_nxt   = ds_target_p0;
            ds_pending_nxt = 1'b0;
          end else begin
            fetch_pc_nxt = fetch_pc_p0 + 32'd4;
          end
`else
          fetch_pc_nxt = fetch_pc_p0 + 32'd4;
`endif
        end
      end
    end
  end

  // Buffer space is reserved at issue, so count the post-edge occupancy.
  always_comb begin
    if (fifo_flush)     cnt_base = '0;
    else if (fifo_keep) cnt_base = (fifo_count >= CW'(2)) ? CW'(1) : '0;
    else                cnt_base = fifo_count - CW'(fifo_pop);
    cnt_next     = cnt_base + CW'(fifo_push);
    req_busy     = vld_p0 && !ack;
    issue        = !req_busy && (cnt_next < CW'(FIFO_DEPTH));
    vld_nxt      = req_busy || issue;
    req_addr_nxt = issue ? fetch_pc_nxt : req_addr_p0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_p0    <= IF_FETCH;
      fetch_pc_p0 <= word_align(RESET_PC);
      vld_p0      <= 1'b0;
      req_addr_p0 <= word_align(RESET_PC);
`ifdef IF_DELAY_SLOT_EN
      ds_pending_p0 <= 1'b0;
`endif
    end else begin
      state_p0    <= state_nxt;
      fetch_pc_p0 <= fetch_pc_nxt;
      vld_p0      <= vld_nxt;
      req_addr_p0 <= req_addr_nxt;
`ifdef IF_DELAY_SLOT_EN
      ds_pending_p0 <= ds_pending_nxt;
`endif
    end
  end

`ifdef IF_DELAY_SLOT_EN
  always_ff @(posedge clk) begin
    ds_target_p0 <= ds_target_nxt;
  end
`endif

  if_fetch_stage_fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fetch_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (fifo_push),
    .push_data  (push_entry),
    .pop        (fifo_pop),
    .flush      (fifo_flush),
    .keep_second(fifo_keep),
    .head_data  (head_entry),
    .count      (fifo_count),
    .empty      (fifo_empty),
    .full       (fifo_full)
  );

  always @(posedge clk) begin
    if (rst) assert (!(fifo_push && fifo_full && !fifo_pop && !fifo_flush && !fifo_keep));
  end

  assign imemReq_o   = vld_p0;
  assign imemAddr_o  = req_addr_p0;
  assign instValid_o = !fifo_empty;
  assign pc_o        = fifo_empty ? 32'h0 : head_entry.pc;
  assign inst_o      = fifo_empty ? NOP : head_entry.inst;

endmodule
